// File: rtl/mult_pkg.sv
// Shared constants and FSM encoding for the multiply scheduler.
package mult_pkg;

  localparam int unsigned WIDTH = 6;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester/response bus between the requesters and the multiply scheduler.
interface mult_scheduler_if #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH,
  parameter int unsigned N_REQ = mult_pkg::N_REQ
);

  logic [N_REQ-1:0]         req;
  logic [N_REQ*WIDTH-1:0]   a_in;
  logic [N_REQ*WIDTH-1:0]   b_in;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [mult_pkg::ID_W-1:0] resp_id;
  logic [2*WIDTH-1:0]       product;

  // Requester / consumer side
  modport master (
    output req, a_in, b_in, resp_ready,
    input  gnt, busy, resp_valid, resp_id, product
  );

  // Scheduler side
  modport slave (
    input  req, a_in, b_in, resp_ready,
    output gnt, busy, resp_valid, resp_id, product
  );

endinterface

// File: rtl/seq_mult_core.sv
// Shift-add unsigned multiplier: one partial-product step per cycle for WIDTH cycles.
module seq_mult_core #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;

  // Load operands on start, then shift/add until the step counter drains
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      mcand   <= PW'(a);
      mplier  <= b;
      product <= '0;
      cnt     <= CNT_W'(WIDTH);
    end else if (cnt != '0) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  // High during the final step, so the product is complete from the next cycle on
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter feeding a single sequential multiplier, with a held response.
module mult_scheduler #(
  parameter int unsigned WIDTH = mult_pkg::WIDTH,
  parameter int unsigned N_REQ = mult_pkg::N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  mult_scheduler_if.slave  bus
);

  import mult_pkg::*;

  state_t            state;
  state_t            next_state;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              start;
  logic              core_done;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;
  logic [ID_W-1:0]   resp_id_q;
  logic [N_REQ-1:0]  gnt_c;
  logic [2*WIDTH-1:0] core_product;

  // Round-robin search starting at ptr
  always_comb begin
    logic [ID_W-1:0] idx;
    idx     = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = ID_W'((32'(ptr) + i) % N_REQ);
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // Operand mux for the winning requester
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        a_sel = bus.a_in[i*WIDTH +: WIDTH];
        b_sel = bus.b_in[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_req)        next_state = RUN;
      RUN:     if (core_done)      next_state = DONE;
      DONE:    if (bus.resp_ready) next_state = IDLE;
      default:                     next_state = IDLE;
    endcase
  end

  // Output decode; grant is combinational in the IDLE cycle and masked by reset
  always_comb begin
    gnt_c      = '0;
    start      = 1'b0;
    bus.busy       = (state != IDLE);
    bus.resp_valid = (state == DONE);
    if (state == IDLE && any_req && !rst) begin
      gnt_c[winner] = 1'b1;
      start         = 1'b1;
    end
  end

  // Pointer advance and response owner capture at grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      resp_id_q <= '0;
    end else if (start) begin
      ptr       <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + ID_W'(1);
      resp_id_q <= winner;
    end
  end

  seq_mult_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_sel),
    .b       (b_sel),
    .product (core_product),
    .done    (core_done)
  );

  assign bus.gnt     = gnt_c;
  assign bus.resp_id = resp_id_q;
  assign bus.product = core_product;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed + randomized bench for mult_scheduler against a transaction-level model.
module tb_mult_scheduler;

  localparam int W = 6;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_scheduler_if #(.WIDTH(W), .N_REQ(N)) bus ();

  mult_scheduler #(.WIDTH(W), .N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int op_a[N];
  int op_b[N];
  int m_ptr;
  int last_gnt;
  bit track_gap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      bus.a_in[i*W +: W] = W'(op_a[i]);
      bus.b_in[i*W +: W] = W'(op_b[i]);
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_a[i] = int'($urandom_range(0, 63));
      op_b[i] = int'($urandom_range(0, 63));
    end
  endtask

  // Model: first requester at or after the rotating pointer wins
  function automatic int pick(input logic [3:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic scramble_inputs();
    bus.req  = 4'($urandom);
    bus.a_in = 24'($urandom);
    bus.b_in = 24'($urandom);
  endtask

  // One transaction from an IDLE cycle; returns positioned in the following IDLE cycle
  task automatic txn(input logic [3:0] mask, input int hold, input bit drop, input bit scramble);
    int w;
    int exp_p;
    logic [3:0] cur;
    w     = pick(mask);
    exp_p = op_a[w] * op_b[w];
    cur   = mask;
    bus.req        = cur;
    drive_ops();
    bus.resp_ready = (hold == 0);
    sample();
    check("gnt", 32'(bus.gnt), 32'(1 << w));
    check("busy_at_gnt", 32'(bus.busy), 32'd0);
    check("valid_at_gnt", 32'(bus.resp_valid), 32'd0);
    if (track_gap) begin
      if (last_gnt >= 0) check("gnt_interval", 32'(cyc - last_gnt), 32'd8);
      last_gnt = cyc;
    end
    m_ptr = (w + 1) % N;
    if (drop) cur[w] = 1'b0;
    for (int c = 1; c <= W; c++) begin
      next_cycle();
      if (scramble) scramble_inputs();
      else bus.req = cur;
      sample();
      check("run_gnt", 32'(bus.gnt), 32'd0);
      check("run_busy", 32'(bus.busy), 32'd1);
      check("run_valid", 32'(bus.resp_valid), 32'd0);
    end
    for (int c = 0; c <= hold; c++) begin
      next_cycle();
      if (c == hold) bus.resp_ready = 1'b1;
      if (scramble) scramble_inputs();
      sample();
      check("done_valid", 32'(bus.resp_valid), 32'd1);
      check("done_product", 32'(bus.product), 32'(exp_p));
      check("done_id", 32'(bus.resp_id), 32'(w));
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_gnt", 32'(bus.gnt), 32'd0);
    end
    next_cycle();
  endtask

  initial begin
    rst            = 1'b1;
    bus.req        = '0;
    bus.a_in       = '0;
    bus.b_in       = '0;
    bus.resp_ready = 1'b0;
    track_gap      = 1'b0;
    last_gnt       = -1;
    m_ptr          = 0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = 0;
      op_b[i] = 0;
    end

    // Reset state, including grant suppression while rst is high
    next_cycle();
    next_cycle();
    bus.req = 4'hF;
    sample();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_id", 32'(bus.resp_id), 32'd0);
    next_cycle();
    rst     = 1'b0;
    bus.req = '0;

    // Single request 5*7
    op_a[0] = 5;  op_b[0] = 7;
    txn(4'b0001, 0, 1'b1, 1'b0);

    // Extremes
    op_a[1] = 63; op_b[1] = 63;
    txn(4'b0010, 0, 1'b1, 1'b0);
    op_a[2] = 0;  op_b[2] = 45;
    txn(4'b0100, 0, 1'b1, 1'b0);

    // Random traffic with inputs scrambled while busy
    for (int k = 0; k < 8; k++) begin
      logic [3:0] m;
      rand_ops();
      m = 4'($urandom_range(1, 15));
      txn(m, 0, 1'b1, 1'b1);
    end

    // Back-pressure in DONE, then IDLE one cycle after acceptance
    rand_ops();
    txn(4'($urandom_range(1, 15)), 5, 1'b1, 1'b0);
    bus.req = '0;
    sample();
    check("post_hold_busy", 32'(bus.busy), 32'd0);
    check("post_hold_valid", 32'(bus.resp_valid), 32'd0);
    next_cycle();

    // Pointer rotation: after requester 2, 1001 goes to 3 then 0
    rand_ops();
    txn(4'b0100, 0, 1'b1, 1'b0);
    txn(4'b1001, 0, 1'b1, 1'b0);
    txn(4'b1001, 0, 1'b1, 1'b0);

    // Reset in the third RUN cycle abandons the operation and clears the pointer
    rand_ops();
    bus.req        = 4'b0100;
    drive_ops();
    bus.resp_ready = 1'b1;
    sample();
    check("pre_rst_gnt", 32'(bus.gnt), 32'(1 << pick(4'b0100)));
    next_cycle();
    bus.req = '0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    sample();
    check("rst_run_gnt", 32'(bus.gnt), 32'd0);
    check("rst_run_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    sample();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.resp_valid), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    check("abort_id", 32'(bus.resp_id), 32'd0);
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    m_ptr = 0;
    next_cycle();
    rand_ops();
    txn(4'b1001, 0, 1'b1, 1'b0);

    // All four held: grants 0,1,2,3,0 every 8 cycles
    rst = 1'b1;
    bus.req = '0;
    next_cycle();
    rst   = 1'b0;
    m_ptr = 0;
    track_gap = 1'b1;
    last_gnt  = -1;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      txn(4'hF, 0, 1'b0, 1'b0);
    end
    track_gap = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
